div_seq_ctrl: RTL

Sequential controller that computes a 2W/W restoring division one quotient bit per cycle, from MSB to LSB. Each cycle evaluates one row of the subtractor array: a trial subtract, a borrow-based quotient decision, and a restore mux. It sits between a valid/ready requester and a consumer. It exposes divide-by-zero and overflow detection, which the combinational array lacks. It is the time-multiplexed counterpart of the full array divider.

---
 rtl/div_ctrl_pkg.sv | 19 +
 rtl/div_step.sv | 33 +++
 rtl/div_seq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the sequential restoring divider controller.
package div_ctrl_pkg;

  localparam int unsigned DEF_D_W = 8;

  // Wide all-ones pattern, truncated to the configured quotient width at use.
  localparam logic [63:0] Q_ALL_ONES = '1;

  localparam int unsigned FLAG_W   = 2;
  localparam int unsigned FLAG_DBZ = 0;
  localparam int unsigned FLAG_OVF = 1;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division row: exact borrow-chain trial subtract of d from
// {prem, n_bit}, quotient bit from the final borrow, then restore mux.
module div_step #(
  parameter int unsigned D_W = 8
) (
  input  logic [D_W-1:0] prem,
  input  logic           n_bit,
  input  logic [D_W-1:0] d,
  output logic [D_W-1:0] prem_next,
  output logic           q_bit
);

  logic [D_W-1:0] a;
  logic [D_W-1:0] diff;
  logic [D_W:0]   bw;
  logic           top;

  // tmp = {prem, n_bit} is W+1 bits; a is its low W bits, top its MSB.
  always_comb begin
    a     = {prem[D_W-2:0], n_bit};
    top   = prem[D_W-1];
    diff  = '0;
    bw    = '0;
    for (int unsigned i = 0; i < D_W; i++) begin
      diff[i]  = a[i] ^ d[i] ^ bw[i];
      bw[i+1]  = (~a[i] & d[i]) | (~(a[i] ^ d[i]) & bw[i]);
    end
    // Divisor MSB extension is zero, so the last cell only propagates borrow.
    q_bit     = ~(~top & bw[D_W]);
    prem_next = q_bit ? diff : a;
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential 2W/W restoring divider, one quotient bit per cycle, MSB first.
// Optional DIV_TRUNC_EN: trunc input stops iteration early at bit index trunc.
module div_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned D_W   = DEF_D_W,
  parameter int unsigned CNT_W = $clog2(D_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*D_W-1:0]   n,
  input  logic [D_W-1:0]     d,
`ifdef DIV_TRUNC_EN
  input  logic [CNT_W-1:0]   trunc,
`endif
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_W-1:0]     q,
  output logic [D_W-1:0]     r,
  output logic               dbz,
  output logic               ovf
);

  state_t              state, state_next;
  logic [D_W-1:0]      n_hi, n_lo, d_q, prem;
  logic [D_W-1:0]      step_prem, step_d, prem_next;
  logic                step_bit, q_bit, idle, start_dbz, start_err;
  logic [CNT_W-1:0]    cnt, stop, stop_in;
  logic [FLAG_W-1:0]   flags, err_flags;

  assign n_hi      = n[2*D_W-1:D_W];
  assign idle      = (state == IDLE);
  assign start_dbz = (d == '0);
  assign start_err = start_dbz || (n_hi >= d);

`ifdef DIV_TRUNC_EN
  logic [CNT_W-1:0] stop_q;
  assign stop_in = (trunc > CNT_W'(D_W-1)) ? CNT_W'(D_W-1) : trunc;
  assign stop    = stop_q;
  always_ff @(posedge clk) begin
    if (rst)                 stop_q <= '0;
    else if (idle && in_valid) stop_q <= stop_in;
  end
`else
  assign stop_in = '0;
  assign stop    = '0;
`endif

  always_comb begin
    err_flags           = '0;
    err_flags[FLAG_DBZ] = start_dbz;
    err_flags[FLAG_OVF] = ~start_dbz;
  end

  // The first row is evaluated on the accept edge straight from the inputs.
  assign step_prem = idle ? n_hi : prem;
  assign step_bit  = idle ? n[D_W-1] : n_lo[cnt];
  assign step_d    = idle ? d : d_q;

  div_step #(.D_W(D_W)) u_step (
    .prem      (step_prem),
    .n_bit     (step_bit),
    .d         (step_d),
    .prem_next (prem_next),
    .q_bit     (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) begin
        if (start_err || (stop_in == CNT_W'(D_W-1))) state_next = DONE;
        else                                          state_next = ITER;
      end
      ITER: if (cnt == stop) state_next = DONE;
      DONE: if (out_ready)   state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      n_lo      <= '0;
      d_q       <= '0;
      prem      <= '0;
      cnt       <= '0;
      q         <= '0;
      r         <= '0;
      flags     <= '0;
    end else begin
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
      out_valid <= (state_next == DONE);
      if (idle && in_valid) begin
        n_lo <= n[D_W-1:0];
        d_q  <= d;
        if (start_err) begin
          q     <= D_W'(Q_ALL_ONES);
          r     <= n_hi;
          flags <= err_flags;
        end else begin
          prem  <= prem_next;
          q     <= {q_bit, (D_W-1)'(0)};
          cnt   <= CNT_W'(D_W-2);
          flags <= '0;
          if (stop_in == CNT_W'(D_W-1)) r <= prem_next;
        end
      end else if (state == ITER) begin
        prem   <= prem_next;
        q[cnt] <= q_bit;
        if (cnt == stop) r   <= prem_next;
        else             cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign dbz = flags[FLAG_DBZ];
  assign ovf = flags[FLAG_OVF];

endmodule
